// File: rtl/cpu_regfile_pkg.sv
// Shared sizing defaults, address-width helper and data/address types for the
// multi-port register file and its busy scoreboard.
package cpu_regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 32;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int AW_DEFAULT = addr_width(DEPTH_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] reg_data_t;

endpackage

// File: rtl/cpu_regfile_scoreboard.sv
// Per-register busy scoreboard: pending-writeback tracking with
// flush > issue > writeback-clear priority and per-read-port busy lookup.
import cpu_regfile_pkg::*;

module cpu_regfile_scoreboard #(
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] raddr,
    input  logic [NUM_WR-1:0]    we,
    input  logic [NUM_WR*AW-1:0] waddr,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_addr,
    input  logic                 flush,
    output logic [NUM_RD-1:0]    rbusy,
    output logic                 busy_any
);

    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_next_s;
    logic              busy_any_r;
    logic [NUM_RD-1:0] wr_hit_s;
    logic [NUM_RD-1:0] iss_hit_s;
    logic [NUM_RD-1:0] rbusy_s;

    // Next busy vector: writeback clears first so a same-cycle issue to the same register wins
    always_comb begin
        busy_next_s = busy_r;
        if (flush) begin
            busy_next_s = {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                busy_next_s[waddr[i*AW +: AW]] = we[i] ? 1'b0 : busy_next_s[waddr[i*AW +: AW]];
            end
            busy_next_s[issue_addr] = issue_en ? 1'b1 : busy_next_s[issue_addr];
        end
        busy_next_s[0] = (ZERO_REG != 0) ? 1'b0 : busy_next_s[0];
    end

    // Busy state and its OR-reduction, both held in flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_any_r <= 1'b0;
        end else begin
            busy_r     <= busy_next_s;
            busy_any_r <= |busy_next_s;
        end
    end

    // Per-port lookup; a landing writeback hides the stale busy bit unless re-issued now
    always_comb begin
        wr_hit_s  = {NUM_RD{1'b0}};
        iss_hit_s = {NUM_RD{1'b0}};
        rbusy_s   = {NUM_RD{1'b0}};
        for (int j = 0; j < NUM_RD; j++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                wr_hit_s[j] = wr_hit_s[j] | (we[i] && (waddr[i*AW +: AW] == raddr[j*AW +: AW]));
            end
            iss_hit_s[j] = issue_en && (issue_addr == raddr[j*AW +: AW]);
            rbusy_s[j]   = busy_r[raddr[j*AW +: AW]]
                           & ~((BYPASS != 0) & wr_hit_s[j] & ~iss_hit_s[j]);
        end
    end

    assign rbusy    = rbusy_s;
    assign busy_any = busy_any_r;

endmodule

// File: rtl/cpu_regfile_mp.sv
// Parametrised multi-port register file: storage, write-port arbitration,
// optional write-to-read bypass and hard-wired zero register.
import cpu_regfile_pkg::*;

module cpu_regfile_mp #(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic [NUM_WR-1:0]      we,
    input  logic [NUM_WR*AW-1:0]   waddr,
    input  logic [NUM_WR*XLEN-1:0] wdata,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    input  logic                   flush,
    output logic                   busy_any
);

    logic [DEPTH-1:0][XLEN-1:0] mem_r;
    logic [NUM_RD*XLEN-1:0]     rdata_s;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == {AW{1'b0}});
    endfunction

    // Storage update in ascending port order so the highest same-address port lands last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= {(DEPTH*XLEN){1'b0}};
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] && !is_zero_reg(waddr[i*AW +: AW])) begin
                    mem_r[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes with forwarding from the highest matching write port
    always_comb begin
        rdata_s = {(NUM_RD*XLEN){1'b0}};
        for (int j = 0; j < NUM_RD; j++) begin
            rdata_s[j*XLEN +: XLEN] = mem_r[raddr[j*AW +: AW]];
            for (int i = 0; i < NUM_WR; i++) begin
                rdata_s[j*XLEN +: XLEN] =
                    ((BYPASS != 0) && we[i] && (waddr[i*AW +: AW] == raddr[j*AW +: AW]))
                    ? wdata[i*XLEN +: XLEN] : rdata_s[j*XLEN +: XLEN];
            end
            rdata_s[j*XLEN +: XLEN] = is_zero_reg(raddr[j*AW +: AW])
                                      ? {XLEN{1'b0}} : rdata_s[j*XLEN +: XLEN];
        end
    end

    assign rdata = rdata_s;

    cpu_regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr      (raddr),
        .we         (we),
        .waddr      (waddr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .rbusy      (rbusy),
        .busy_any   (busy_any)
    );

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Bench for cpu_regfile_mp: directed scenarios plus random traffic against a
// behavioural model, on a bypassing and a non-bypassing instance side by side.
module tb_cpu_regfile_mp;
    import cpu_regfile_pkg::*;

    localparam int AW = 5;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [2*AW-1:0] raddr = '0;
    logic [1:0]      we = '0;
    logic [2*AW-1:0] waddr = '0;
    logic [2*XL-1:0] wdata = '0;
    logic            issue_en = 1'b0;
    logic [AW-1:0]   issue_addr = '0;
    logic            flush = 1'b0;
    logic [2*XL-1:0] rdata_b, rdata_n;
    logic [1:0]      rbusy_b, rbusy_n;
    logic            busy_any_b, busy_any_n;

    int n_checks = 0;
    int n_fail   = 0;

    reg_data_t   m_mem [32];
    logic [31:0] m_busy;

    always #5 clk = ~clk;

    cpu_regfile_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_any(busy_any_b));

    cpu_regfile_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_en(issue_en),
        .issue_addr(issue_addr), .flush(flush), .busy_any(busy_any_n));

    // Expected read data: stored value, optionally overridden by the last matching write port
    function automatic reg_data_t exp_rd(input int j, input bit byp);
        reg_addr_t a = raddr[j*AW +: AW];
        reg_data_t v = m_mem[a];
        if (byp) for (int i = 0; i < 2; i++)
            if (we[i] && waddr[i*AW +: AW] == a) v = wdata[i*XL +: XL];
        if (a == 5'd0) v = 32'd0;
        return v;
    endfunction

    function automatic logic exp_busy(input int j, input bit byp);
        reg_addr_t a = raddr[j*AW +: AW];
        bit hit = 1'b0;
        for (int i = 0; i < 2; i++) if (we[i] && waddr[i*AW +: AW] == a) hit = 1'b1;
        if (byp && hit && !(issue_en && issue_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_mem[k] = 32'd0;
        m_busy = 32'd0;
    endtask

    // One clock: compute next model state from current inputs, commit after the edge
    task automatic step();
        reg_data_t   nm [32];
        logic [31:0] nb;
        nm = m_mem;
        nb = m_busy;
        for (int i = 0; i < 2; i++)
            if (we[i] && waddr[i*AW +: AW] != 5'd0) nm[waddr[i*AW +: AW]] = wdata[i*XL +: XL];
        if (flush) nb = 32'd0;
        else begin
            for (int i = 0; i < 2; i++) if (we[i]) nb[waddr[i*AW +: AW]] = 1'b0;
            if (issue_en) nb[issue_addr] = 1'b1;
        end
        nb[0] = 1'b0;
        @(posedge clk);
        m_mem  = nm;
        m_busy = nb;
        #1;
    endtask

    task automatic idle();
        we = 2'b00; issue_en = 1'b0; flush = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        we[port] = 1'b1; waddr[port*AW +: AW] = a; wdata[port*XL +: XL] = d;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        raddr = {5'd5, 5'd0};
        #1;
        n_checks++; if (rdata_b !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata_b); end
        n_checks++; if (busy_any_b !== 1'b0 || rbusy_b !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b/%b exp 0/00", busy_any_b, rbusy_b); end
        #5 rst_n = 1'b1;
        wr(0, 5'd5, 32'h1234); issue_en = 1'b1; issue_addr = 5'd5;
        step();
        idle();
        #1;
        n_checks++; if (rdata_b[63:32] !== 32'h1234 || busy_any_b !== 1'b1) begin n_fail++; $display("FAIL pre_reset got %h/%b exp 00001234/1", rdata_b[63:32], busy_any_b); end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (rdata_b[63:32] !== 32'd0 || rdata_n[63:32] !== 32'd0 || busy_any_b !== 1'b0) begin n_fail++; $display("FAIL mid_reset got %h/%h/%b exp 0/0/0", rdata_b[63:32], rdata_n[63:32], busy_any_b); end
        wr(1, 5'd6, 32'hDEAD_BEEF); issue_en = 1'b1; issue_addr = 5'd6;
        @(posedge clk);
        #1 idle();
        raddr = {5'd6, 5'd6};
        #1;
        n_checks++; if (rdata_n[31:0] !== 32'd0 || rbusy_n[0] !== 1'b0) begin n_fail++; $display("FAIL reset_dominates got %h/%b exp 0/0", rdata_n[31:0], rbusy_n[0]); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_reg();
        wr(0, 5'd0, 32'hFFFF_FFFF); raddr = {5'd0, 5'd0};
        #1;
        n_checks++; if (rdata_b[31:0] !== 32'd0) begin n_fail++; $display("FAIL zero_bypass got %h exp 0", rdata_b[31:0]); end
        step();
        idle(); issue_en = 1'b1; issue_addr = 5'd0;
        step();
        idle();
        #1;
        n_checks++; if (rdata_b[31:0] !== 32'd0 || rdata_n[31:0] !== 32'd0) begin n_fail++; $display("FAIL zero_read got %h/%h exp 0", rdata_b[31:0], rdata_n[31:0]); end
        n_checks++; if (rbusy_b[0] !== 1'b0 || busy_any_b !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b/%b exp 0/0", rbusy_b[0], busy_any_b); end
    endtask

    task automatic test_bypass();
        wr(0, 5'd7, 32'h1111);
        step();
        idle(); raddr = {5'd1, 5'd7}; wr(0, 5'd7, 32'hA5A5);
        #1;
        n_checks++; if (rdata_b[31:0] !== 32'hA5A5) begin n_fail++; $display("FAIL bypass_on got %h exp 0000a5a5", rdata_b[31:0]); end
        n_checks++; if (rdata_n[31:0] !== 32'h1111) begin n_fail++; $display("FAIL bypass_off got %h exp 00001111", rdata_n[31:0]); end
        step();
        idle();
        #1;
        n_checks++; if (rdata_n[31:0] !== 32'hA5A5) begin n_fail++; $display("FAIL bypass_after got %h exp 0000a5a5", rdata_n[31:0]); end
    endtask

    task automatic test_write_conflict();
        wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); raddr = {5'd3, 5'd3};
        #1;
        n_checks++; if (rdata_b[63:32] !== 32'h22) begin n_fail++; $display("FAIL conflict_bypass got %h exp 00000022", rdata_b[63:32]); end
        step();
        idle();
        #1;
        n_checks++; if (rdata_b[31:0] !== 32'h22 || rdata_n[31:0] !== 32'h22) begin n_fail++; $display("FAIL conflict_store got %h/%h exp 00000022", rdata_b[31:0], rdata_n[31:0]); end
    endtask

    task automatic test_scoreboard();
        raddr = {5'd9, 5'd1}; issue_en = 1'b1; issue_addr = 5'd9;
        #1;
        n_checks++; if (rbusy_b[1] !== 1'b0) begin n_fail++; $display("FAIL sb_not_yet got %b exp 0", rbusy_b[1]); end
        step();
        idle();
        #1;
        n_checks++; if (rbusy_b[1] !== 1'b1 || busy_any_b !== 1'b1) begin n_fail++; $display("FAIL sb_issue got %b/%b exp 1/1", rbusy_b[1], busy_any_b); end
        wr(0, 5'd9, 32'h99); issue_en = 1'b1; issue_addr = 5'd9;
        #1;
        n_checks++; if (rbusy_b[1] !== 1'b1) begin n_fail++; $display("FAIL sb_reissue_comb got %b exp 1", rbusy_b[1]); end
        step();
        idle();
        #1;
        n_checks++; if (rbusy_b[1] !== 1'b1 || rbusy_n[1] !== 1'b1) begin n_fail++; $display("FAIL sb_reissue got %b/%b exp 1/1", rbusy_b[1], rbusy_n[1]); end
        wr(1, 5'd9, 32'h9A);
        #1;
        n_checks++; if (rbusy_b[1] !== 1'b0 || rbusy_n[1] !== 1'b1 || busy_any_b !== 1'b1) begin n_fail++; $display("FAIL sb_mask got %b/%b/%b exp 0/1/1", rbusy_b[1], rbusy_n[1], busy_any_b); end
        step();
        idle();
        #1;
        n_checks++; if (rbusy_b[1] !== 1'b0 || rbusy_n[1] !== 1'b0 || busy_any_b !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %b/%b/%b exp 0/0/0", rbusy_b[1], rbusy_n[1], busy_any_b); end
    endtask

    task automatic test_flush();
        wr(0, 5'd2, 32'hC0DE); step(); idle();
        for (int k = 2; k <= 6; k += 2) begin
            issue_en = 1'b1; issue_addr = 5'(k); step();
        end
        idle();
        #1;
        n_checks++; if (busy_any_b !== 1'b1) begin n_fail++; $display("FAIL flush_pre got %b exp 1", busy_any_b); end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd8;
        step();
        idle(); raddr = {5'd8, 5'd2};
        #1;
        n_checks++; if (busy_any_b !== 1'b0 || busy_any_n !== 1'b0 || rbusy_b !== 2'b00) begin n_fail++; $display("FAIL flush_busy got %b/%b/%b exp 0/0/00", busy_any_b, busy_any_n, rbusy_b); end
        n_checks++; if (rdata_b[31:0] !== 32'hC0DE) begin n_fail++; $display("FAIL flush_data got %h exp 0000c0de", rdata_b[31:0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            raddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            we         = 2'($urandom);
            waddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata      = {32'($urandom), 32'($urandom)};
            issue_en   = 1'($urandom);
            issue_addr = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            #1;
            for (int j = 0; j < 2; j++) begin
                n_checks++; if (rdata_b[j*XL +: XL] !== exp_rd(j, 1'b1)) begin n_fail++; $display("FAIL rand_rdata_byp c%0d p%0d got %h exp %h", c, j, rdata_b[j*XL +: XL], exp_rd(j, 1'b1)); end
                n_checks++; if (rdata_n[j*XL +: XL] !== exp_rd(j, 1'b0)) begin n_fail++; $display("FAIL rand_rdata_nob c%0d p%0d got %h exp %h", c, j, rdata_n[j*XL +: XL], exp_rd(j, 1'b0)); end
                n_checks++; if (rbusy_b[j] !== exp_busy(j, 1'b1)) begin n_fail++; $display("FAIL rand_rbusy_byp c%0d p%0d got %b exp %b", c, j, rbusy_b[j], exp_busy(j, 1'b1)); end
                n_checks++; if (rbusy_n[j] !== exp_busy(j, 1'b0)) begin n_fail++; $display("FAIL rand_rbusy_nob c%0d p%0d got %b exp %b", c, j, rbusy_n[j], exp_busy(j, 1'b0)); end
            end
            n_checks++; if (busy_any_b !== (|m_busy) || busy_any_n !== (|m_busy)) begin n_fail++; $display("FAIL rand_busy_any c%0d got %b/%b exp %b", c, busy_any_b, busy_any_n, |m_busy); end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_write_conflict();
        test_scoreboard();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
